// File: rtl/down_sram_drain.sv
// Drains an inclusive address range from the down SRAM and streams the rows
// out through a small first-word-fall-through buffer with credit-based read throttling.
`timescale 1ns/1ps
module down_sram_drain #(
    parameter int NUM_COL              = 4,
    parameter int OUT_DATA_WIDTH       = 16,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int BUF_DEPTH            = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_end_addr,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_rd_addr,
    input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_rd_data,
    output logic [NUM_COL*OUT_DATA_WIDTH-1:0] o_data,
    output logic                              o_valid,
    input  logic                              i_ready
);
    localparam int AW = LOG2_SRAM_BANK_DEPTH;
    localparam int DW = NUM_COL * OUT_DATA_WIDTH;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW:0]   BUF_DEPTH_W = (CW+1)'(BUF_DEPTH);
    localparam logic [AW-1:0] ONE_A       = AW'(1);
    localparam logic [AW:0]   ONE_R       = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t                    state, state_nxt;
    logic [AW-1:0]             addr;
    logic [AW:0]               remaining;
    logic                      inflight;
    logic [BUF_DEPTH-1:0][DW-1:0] fifo_q;
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             count;
    logic                      pop, push, credit, issue;
    logic [AW-1:0]             span;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign span    = i_end_addr - i_start_addr;
    assign o_valid = (count != '0);
    assign o_data  = o_valid ? fifo_q[rd_ptr] : '0;
    assign pop     = o_valid & i_ready;
    assign push    = inflight;

    // A pop this cycle frees a slot for a read issued in the same cycle.
    assign credit  = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (BUF_DEPTH_W + {{CW{1'b0}}, pop});
    assign issue   = (state == READ) && credit;

    assign o_rd_en   = issue;
    assign o_rd_addr = issue ? addr : '0;
    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = READ;
            READ:    if (issue && remaining == ONE_R) state_nxt = FLUSH;
            FLUSH:   if (!inflight && count == CW'(pop)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && i_start) begin
                addr      <= i_start_addr;
                remaining <= {1'b0, span} + ONE_R;
            end else if (issue) begin
                addr      <= addr + ONE_A;
                remaining <= remaining - ONE_R;
            end
        end
    end

    // Returned rows land unconditionally; the credit check guarantees a free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= i_rd_data;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
